// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, drives ROM word address, queues {pc, instr} for decode.
// Latency: address issued at edge E0, pushed at E1, out_valid high after E1; redirect target valid 2 edges after redirect.
// Backpressure: 2-entry buffer; issue stalls when buffered + in-flight would exceed 2, so no ROM read is ever dropped.
module ifetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               ROM_AW   = 13,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instr
);

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_req_valid;
    logic [XLEN-1:0] r_req_pc;
    logic [1:0]      r_count;
    logic [XLEN-1:0] r_hd_pc;
    logic [XLEN-1:0] r_hd_instr;
    logic [XLEN-1:0] r_tl_pc;
    logic [XLEN-1:0] r_tl_instr;

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [2:0]      w_occ;
    logic            w_unused;

    assign rom_addr  = r_fetch_pc[ROM_AW+1:2];
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = r_hd_pc;
    assign out_instr = r_hd_instr;

    assign w_pop   = out_valid & out_ready;
    assign w_push  = r_req_valid & ~redirect_valid;
    // Occupancy after this edge if nothing new were issued; pop implies count >= 1, so no underflow.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_req_valid} - {2'b00, w_pop};
    assign w_issue = ~redirect_valid & (w_occ < 3'd2);

    assign w_unused = ^{redirect_pc[1:0], r_fetch_pc[XLEN-1:ROM_AW+2]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc  <= RESET_PC;
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
            r_count     <= 2'd0;
            r_hd_pc     <= '0;
            r_hd_instr  <= '0;
            r_tl_pc     <= '0;
            r_tl_instr  <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
            r_req_valid <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_issue) begin
                r_req_valid <= 1'b1;
                r_req_pc    <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + XLEN'(4);
            end else begin
                r_req_valid <= 1'b0;
            end

            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            // Head is always slot 0; a pop shifts the tail forward before the push lands.
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_hd_pc    <= r_tl_pc;
                    r_hd_instr <= r_tl_instr;
                    if (w_push) begin
                        r_tl_pc    <= r_req_pc;
                        r_tl_instr <= rom_data;
                    end
                end else if (w_push) begin
                    r_hd_pc    <= r_req_pc;
                    r_hd_instr <= rom_data;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_hd_pc    <= r_req_pc;
                    r_hd_instr <= rom_data;
                end else begin
                    r_tl_pc    <= r_req_pc;
                    r_tl_instr <= rom_data;
                end
            end
        end
    end

endmodule
